// File: rtl/proj_accum_pkg.sv
// Shared types and helpers for the thresholded row/column projection accumulator.
// Holds the frame FSM states, the saturating adder and default geometry.
package proj_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_COLS   = 640;
  localparam int DEF_ROWS   = 480;
  localparam int DEF_COL_AW = $clog2(DEF_COLS);
  localparam int DEF_ROW_AW = $clog2(DEF_ROWS);

  // Add two unsigned values and clamp the result to 2^w-1 instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (sum > lim) begin
      return lim[31:0];
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/proj_bank.sv
// One projection bank: column and row count arrays, each with a write port,
// an asynchronous column read for accumulation and a registered host read port.
module proj_bank import proj_accum_pkg::*; #(
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int CNT_W = 10,
  parameter int CAW   = $clog2(COLS),
  parameter int RAW   = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             col_we,
  input  logic [CAW-1:0]   col_addr,
  input  logic [CNT_W-1:0] col_wdata,
  output logic [CNT_W-1:0] col_rdata,
  input  logic             row_we,
  input  logic [RAW-1:0]   row_addr,
  input  logic [CNT_W-1:0] row_wdata,
  input  logic             rd_en,
  input  logic             rd_sel,
  input  logic [CAW-1:0]   rd_addr,
  output logic [CNT_W-1:0] rd_data
);

  logic [CNT_W-1:0] col_mem_q [COLS];
  logic [CNT_W-1:0] row_mem_q [ROWS];
  logic [CNT_W-1:0] rd_data_d, rd_data_q;
  logic             col_in_s, row_in_s;

  assign col_rdata = col_mem_q[col_addr];
  assign rd_data   = rd_data_q;

  always_comb begin
    col_in_s  = {1'b0, rd_addr} < (CAW+1)'(COLS);
    row_in_s  = {1'b0, rd_addr[RAW-1:0]} < (RAW+1)'(ROWS);
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (rd_sel) begin
        rd_data_d = row_in_s ? row_mem_q[rd_addr[RAW-1:0]] : {CNT_W{1'b0}};
      end else begin
        rd_data_d = col_in_s ? col_mem_q[rd_addr] : {CNT_W{1'b0}};
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Array storage carries no reset; contents are defined by the first completed frame.
  always_ff @(posedge clk) begin
    if (col_we) col_mem_q[col_addr] <= col_wdata;
    if (row_we) row_mem_q[row_addr] <= row_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= {CNT_W{1'b0}};
    else     rd_data_q <= rd_data_d;
  end

endmodule

// File: rtl/proj_accum.sv
// Per-frame thresholded column/row projection counter with a registered host read port.
// Define PROJ_PINGPONG_EN for two banks so the host always reads the last completed frame.
module proj_accum import proj_accum_pkg::*; #(
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int PIX_W = 12,
  parameter int CNT_W = 10
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [PIX_W-1:0]        iDATA,
  input  logic                    iDVAL,
  input  logic                    iFVAL,
  input  logic                    iLVAL,
  input  logic [PIX_W-1:0]        iTHRESH,
  input  logic                    iSTART,
  input  logic                    iRD_REQ,
  input  logic                    iRD_SEL,
  input  logic [$clog2(COLS)-1:0] iRD_ADDR,
  output logic [CNT_W-1:0]        oRD_DATA,
  output logic                    oRD_ACK,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic [15:0]             oFRAME_CNT
);

  localparam int CAW = $clog2(COLS);
  localparam int RAW = $clog2(ROWS);
  localparam int XW  = $clog2(COLS + 1);
  localparam int YW  = $clog2(ROWS + 1);
  localparam logic [XW-1:0] X_END = XW'(COLS);
  localparam logic [YW-1:0] Y_END = YW'(ROWS);

  state_e           state_d, state_q;
  logic [XW-1:0]    x_d, x_q;
  logic [YW-1:0]    y_d, y_q;
  logic [CNT_W-1:0] lsum_d, lsum_q;
  logic [15:0]      fcnt_d, fcnt_q;
  logic             fval_q, lval_q, busy_d, busy_q, done_d, done_q, ack_q;
  logic             pix_s, hit_s, x_in_s, y_in_s, fval_rise_s, fval_fall_s, lval_fall_s;
  logic             accum_s, col_we_s, row_we_s;
  logic [31:0]      col_sum_s, lsum_sum_s;
  logic [CNT_W-1:0] col_cur_s, col_wdata_s;
  logic [CNT_W-1:0] rd0_s;

  always_comb begin
    accum_s     = (state_q == ST_ACCUM);
    pix_s       = iDVAL & iLVAL & iFVAL;
    hit_s       = (iDATA > iTHRESH);
    x_in_s      = (x_q < X_END);
    y_in_s      = (y_q < Y_END);
    fval_rise_s = ~fval_q & iFVAL;
    fval_fall_s = fval_q & ~iFVAL;
    lval_fall_s = lval_q & ~iLVAL;
    col_sum_s   = sat_add(32'(col_cur_s), {31'd0, hit_s}, CNT_W);
    lsum_sum_s  = sat_add(32'(lsum_q), {31'd0, hit_s}, CNT_W);
    // Line 0 overwrites the column so no clear pass is needed between frames.
    col_wdata_s = (y_q == {YW{1'b0}}) ? {{(CNT_W-1){1'b0}}, hit_s} : col_sum_s[CNT_W-1:0];
    col_we_s    = accum_s & pix_s & x_in_s & y_in_s;
    row_we_s    = accum_s & (lval_fall_s | fval_fall_s) & (x_q != {XW{1'b0}}) & y_in_s;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lsum_d  = lsum_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iSTART) state_d = ST_ARMED;
        else        state_d = state_q;
      end
      ST_ARMED: begin
        if (fval_rise_s) begin
          state_d = ST_ACCUM;
          x_d     = {XW{1'b0}};
          y_d     = {YW{1'b0}};
          lsum_d  = {CNT_W{1'b0}};
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_ACCUM: begin
        if (fval_fall_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + 16'd1;
        end else if (pix_s && x_in_s) begin
          x_d    = x_q + XW'(1);
          lsum_d = lsum_sum_s[CNT_W-1:0];
        end else if (lval_fall_s && (x_q != {XW{1'b0}})) begin
          x_d    = {XW{1'b0}};
          lsum_d = {CNT_W{1'b0}};
          y_d    = y_in_s ? (y_q + YW'(1)) : y_q;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ARMED) || (state_d == ST_ACCUM);
  end

  // Frame FSM, edge detectors, counters and registered status outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      x_q     <= {XW{1'b0}};
      y_q     <= {YW{1'b0}};
      lsum_q  <= {CNT_W{1'b0}};
      fcnt_q  <= 16'd0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lsum_q  <= lsum_d;
      fcnt_q  <= fcnt_d;
      fval_q  <= iFVAL;
      lval_q  <= iLVAL;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= iRD_REQ;
    end
  end

  assign oRD_ACK    = ack_q;
  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oFRAME_CNT = fcnt_q;

`ifdef PROJ_PINGPONG_EN
  logic             sel_d, sel_q, rsel_q;
  logic [CNT_W-1:0] rd1_s, col_rd0_s, col_rd1_s;

  always_comb begin
    sel_d     = done_d ? ~sel_q : sel_q;
    col_cur_s = sel_q ? col_rd1_s : col_rd0_s;
  end

  // Accumulation bank select and the bank captured with each host read.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sel_q  <= 1'b0;
      rsel_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      rsel_q <= iRD_REQ ? ~sel_q : rsel_q;
    end
  end

  assign oRD_DATA = rsel_q ? rd1_s : rd0_s;

  proj_bank #(.COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W)) u_bank0 (
    .clk(iCLK), .rst(iRST),
    .col_we(col_we_s & ~sel_q), .col_addr(x_q[CAW-1:0]), .col_wdata(col_wdata_s),
    .col_rdata(col_rd0_s),
    .row_we(row_we_s & ~sel_q), .row_addr(y_q[RAW-1:0]), .row_wdata(lsum_q),
    .rd_en(iRD_REQ), .rd_sel(iRD_SEL), .rd_addr(iRD_ADDR), .rd_data(rd0_s)
  );

  proj_bank #(.COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W)) u_bank1 (
    .clk(iCLK), .rst(iRST),
    .col_we(col_we_s & sel_q), .col_addr(x_q[CAW-1:0]), .col_wdata(col_wdata_s),
    .col_rdata(col_rd1_s),
    .row_we(row_we_s & sel_q), .row_addr(y_q[RAW-1:0]), .row_wdata(lsum_q),
    .rd_en(iRD_REQ), .rd_sel(iRD_SEL), .rd_addr(iRD_ADDR), .rd_data(rd1_s)
  );
`else
  assign oRD_DATA = rd0_s;

  proj_bank #(.COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W)) u_bank0 (
    .clk(iCLK), .rst(iRST),
    .col_we(col_we_s), .col_addr(x_q[CAW-1:0]), .col_wdata(col_wdata_s),
    .col_rdata(col_cur_s),
    .row_we(row_we_s), .row_addr(y_q[RAW-1:0]), .row_wdata(lsum_q),
    .rd_en(iRD_REQ), .rd_sel(iRD_SEL), .rd_addr(iRD_ADDR), .rd_data(rd0_s)
  );
`endif

endmodule

// File: doc/proj_accum.md
# proj_accum

Thresholded row/column projection accumulator for the camera path. It sits after CCD_Capture/RAW2RGB on the pixel clock domain and counts, per image column and per image row, the pixels whose value exceeds a runtime threshold over one frame. Completed projections are exposed to the HPS through a registered request/acknowledge read port. It generalises the ad-hoc row/column accumulation in the top level: parametrised geometry and widths, saturating counts, explicit frame state machine, and optional ping-pong banking.

## Interface
Parameters:
- COLS, 640, active pixels per line; x addresses 0..COLS-1
- ROWS, 480, active lines per frame; y addresses 0..ROWS-1
- PIX_W, 12, pixel data width
- CNT_W, 10, projection counter width; saturating

Ports:
- iCLK  in  1  pixel clock; all logic on rising edge
- iRST  in  1  asynchronous, active-high reset
- iDATA  in  PIX_W  pixel value, qualified by iDVAL
- iDVAL  in  1  pixel valid
- iFVAL  in  1  frame valid
- iLVAL  in  1  line valid
- iTHRESH  in  PIX_W  pixel counts when iDATA > iTHRESH (strict)
- iSTART  in  1  arm one capture (level or pulse, sampled in IDLE/DONE)
- iRD_REQ  in  1  read request, one-cycle pulse
- iRD_SEL  in  1  0 = column array, 1 = row array
- iRD_ADDR  in  $clog2(COLS)  index; row reads use the low $clog2(ROWS) bits
- oRD_DATA  out  CNT_W  read data, valid with oRD_ACK
- oRD_ACK  out  1  one-cycle acknowledge
- oBUSY  out  1  high in ARMED or ACCUM
- oDONE  out  1  one-cycle pulse on frame completion
- oFRAME_CNT  out  16  completed frames, wraps

## Operation
- States: IDLE, ARMED, ACCUM, DONE.
- IDLE/DONE: iSTART=1 -> ARMED. Otherwise hold.
- ARMED: wait for iFVAL rising edge (previous 0, current 1) -> ACCUM. If iFVAL is already high on entry, wait for the next frame.
- ACCUM: x counter increments on each iDVAL & iLVAL & iFVAL. Hit = (iDATA > iTHRESH).
  - Column: col[x] <= (y==0) ? hit : sat(col[x] + hit). The first line overwrites, so no clear pass is needed.
  - Row: a line accumulator sums hits. On iLVAL falling edge with at least one pixel seen: row[y] <= line sum, clear the line sum, y+1, x<=0.
  - x >= COLS: pixel ignored. y >= ROWS: line ignored.
  - iFVAL falling -> DONE. If iLVAL is still high, flush the line sum into row[y] first.
- Entering DONE: oDONE pulse, oFRAME_CNT+1.
- Saturation: sums clamp at 2^CNT_W-1 and never wrap.
- Read: request sampled -> oRD_DATA/oRD_ACK registered next cycle. Address out of range returns 0.
- iSTART during ARMED/ACCUM is ignored.
- Reset: state IDLE, oRD_DATA=0, oRD_ACK=0, oBUSY=0, oDONE=0, oFRAME_CNT=0, counters 0, bank select 0. Array contents are undefined until the first completed frame. Reset mid-frame abandons the frame with no oDONE.

## Timing
- Column read-modify-write: single cycle. Back-to-back iDVAL every cycle is supported with no stall.
- Row write: cycle after iLVAL falls.
- oDONE: cycle after iFVAL falls is observed low.
- Read latency: 1 cycle. Requests may issue every cycle.
- A read and an accumulation write to the same bank and address in the same cycle return the pre-write value.

## Configuration
- PROJ_PINGPONG_EN defined: two banks. Accumulation writes bank[sel] and host reads bank[~sel]; sel toggles on entry to DONE. The host always reads the last completed frame, and accumulation may continue immediately on iSTART.
- Not defined: one bank. Host reads see in-progress data during ACCUM and are valid only in IDLE/DONE.

## Structure
- Package proj_accum_pkg holds:
  - the state enum (IDLE, ARMED, ACCUM, DONE)
  - the saturating-add function
  - the address-width localparams derived from COLS/ROWS
- Sub-module proj_bank holds one column array and one row array, each with a write port and a registered read port. It is instantiated once, or twice under PROJ_PINGPONG_EN.

## Test plan
- COLS=8, ROWS=4, iTHRESH=100, all pixels 200, one frame -> every col=4, every row=8, one oDONE, oFRAME_CNT=1.
- Checkerboard 0/255, thresh=100 -> col[x]=2 for all x, row[y]=4 for all y; a pixel equal to thresh (100) is not counted.
- CNT_W=2, all pixels hit, ROWS=4 -> col[x] saturates at 3, not 0.
- Extra pixels beyond COLS (10 per line) and extra lines beyond ROWS -> ignored, counts identical to the first test.
- iFVAL falls with iLVAL high after 5 pixels -> row[last]=5, oDONE asserted.
- PROJ_PINGPONG_EN: frame A all hits, then frame B all misses; reads during B -> frame A values. After B's oDONE, reads return 0. Reset mid-B -> IDLE, no oDONE, oFRAME_CNT=0.
